// File: rtl/axi_slave_read_pkg.sv
// Shared AXI definitions: default widths, burst and response encodings,
// and the read-slave state encoding.
package axi_pkg;

    localparam int ID_W   = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CAPT  = 2'd2,
        SEND  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/axi_slave_read_if.sv
// AXI read address and read data channels bundled as one interface.
interface axi_slave_read_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;

    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

endinterface

// File: rtl/axi_slave_read_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// WRAP with an illegal length (not 2, 4, 8 or 16 beats) and the reserved
// burst type both advance like INCR.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] region;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] wrap_addr;
    logic              wrap_legal;

    // Step, wrap region and both candidate addresses.
    always_comb begin
        step       = ADDR_W'(1) << size;
        incr_addr  = addr + step;
        region     = (ADDR_W'(len) + ADDR_W'(1)) * step;
        wrap_mask  = region - ADDR_W'(1);
        wrap_addr  = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        // len+1 must be a power of two and at least 2 beats.
        wrap_legal = (len != '0) && ((len & (len + LEN_W'(1))) == '0);
    end

    // Select by burst type.
    always_comb begin
        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = wrap_legal ? wrap_addr : incr_addr;
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_read.sv
// AXI read-channel slave: accepts one AR at a time, walks the burst and
// fetches each beat from a 1-cycle-latency memory port, returning it on R
// with full RVALID/RREADY backpressure.
module axi_slave_read
    import axi_pkg::*;
#(
    parameter int ID_W   = axi_pkg::ID_W,
    parameter int ADDR_W = axi_pkg::ADDR_W,
    parameter int DATA_W = axi_pkg::DATA_W,
    parameter int LEN_W  = axi_pkg::LEN_W
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi_slave_read_if.slave   axi,
    input  logic              ar_block,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    rd_state_t         state_reg, state_next;
    logic [ID_W-1:0]   id_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [2:0]        size_reg;
    logic [1:0]        burst_reg;
    logic [LEN_W-1:0]  beat_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [ADDR_W-1:0] next_addr;

    logic ar_hs;
    logic r_hs;
    logic r_last;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .addr      (addr_reg),
        .len       (len_reg),
        .size      (size_reg),
        .burst     (burst_reg),
        .next_addr (next_addr)
    );

    assign r_last = (beat_reg == len_reg);
    assign ar_hs  = (state_reg == IDLE) && axi.ARVALID && !ar_block;
    assign r_hs   = (state_reg == SEND) && axi.RREADY;
    assign busy   = (state_reg != IDLE);

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request latch, beat counter, address walk and read-data capture.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_reg    <= '0;
            addr_reg  <= '0;
            len_reg   <= '0;
            size_reg  <= '0;
            burst_reg <= '0;
            beat_reg  <= '0;
            rdata_reg <= '0;
        end else begin
            if (ar_hs) begin
                id_reg    <= axi.ARID;
                addr_reg  <= axi.ARADDR;
                len_reg   <= axi.ARLEN;
                size_reg  <= axi.ARSIZE;
                burst_reg <= axi.ARBURST;
                beat_reg  <= '0;
            end
            if (state_reg == CAPT) begin
                rdata_reg <= mem_rdata;
            end
            if (r_hs && !r_last) begin
                beat_reg <= beat_reg + LEN_W'(1);
                addr_reg <= next_addr;
            end
        end
    end

    // Next state and all channel outputs; everything idles at zero, and
    // ARREADY is gated by reset so it drops without waiting for a clock.
    always_comb begin
        state_next  = state_reg;
        axi.ARREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RDATA   = '0;
        axi.RID     = '0;
        axi.RLAST   = 1'b0;
        axi.RRESP   = RESP_OKAY;
        mem_ren     = 1'b0;
        mem_addr    = '0;
        case (state_reg)
            IDLE: begin
                axi.ARREADY = ARESETn && !ar_block;
                if (ar_hs) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                mem_ren    = 1'b1;
                mem_addr   = addr_reg;
                state_next = CAPT;
            end
            CAPT: begin
                state_next = SEND;
            end
            SEND: begin
                axi.RVALID = 1'b1;
                axi.RDATA  = rdata_reg;
                axi.RID    = id_reg;
                axi.RLAST  = r_last;
                axi.RRESP  = (burst_reg == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
                if (r_hs) begin
                    state_next = r_last ? IDLE : FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
